// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: OAM DMA sequencer states and PPU register indices.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  localparam logic [2:0] PPU_OAMDATA_IDX = 3'd4;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: on a $4014 write, halts the CPU and copies one 256-byte page
// into the PPU OAMDATA register as alternating read/write CPU cycles.
module oam_dma
  import ppu_pkg::*;
#(
  parameter logic [2:0] OAMDATA_IDX = PPU_OAMDATA_IDX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        dma_trigger,
  input  logic [7:0]  dma_page,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic        ppu_reg_cs,
  output logic [2:0]  ppu_reg_addr,
  output logic        ppu_WE,
  output logic [7:0]  ppu_data_out,
  output logic        cpu_halt,
  output logic        dma_busy
);

  dma_state_t  state;
  logic        parity;
  logic [7:0]  count;
  logic [7:0]  page;
  logic [7:0]  data;
  logic [15:0] addr_q;
  logic [2:0]  reg_addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      parity     <= 1'b0;
      count      <= 8'h00;
      page       <= 8'h00;
      data       <= 8'h00;
      addr_q     <= 16'h0000;
      reg_addr_q <= 3'd0;
    end else if (cpu_ce) begin
      parity <= ~parity;
      case (state)
        ST_IDLE: begin
          if (dma_trigger) begin
            state <= ST_HALT;
            page  <= dma_page;
            count <= 8'h00;
          end
        end
        ST_HALT: begin
          // parity=0 here means the following cycle is odd: burn one to align reads
          state  <= (!parity) ? ST_ALIGN : ST_READ;
          addr_q <= {page, count};
        end
        ST_ALIGN: state <= ST_READ;
        ST_READ: begin
          data       <= mem_data_in;
          reg_addr_q <= OAMDATA_IDX;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          count <= count + 8'd1;
          if (count == 8'hFF) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_READ;
            addr_q <= {page, count + 8'd1};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are qualified by cpu_ce so they never exceed one clk per CPU cycle.
  assign mem_rd       = cpu_ce && (state == ST_READ);
  assign ppu_WE       = cpu_ce && (state == ST_WRITE);
  assign ppu_reg_cs   = ppu_WE;
  assign mem_addr     = addr_q;
  assign ppu_reg_addr = reg_addr_q;
  assign ppu_data_out = data;
  assign cpu_halt     = (state != ST_IDLE);
  assign dma_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes expected reads/writes, a negedge monitor pops and compares.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        dma_trigger = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_in;
  logic        ppu_reg_cs;
  logic [2:0]  ppu_reg_addr;
  logic        ppu_WE;
  logic [7:0]  ppu_data_out;
  logic        cpu_halt;
  logic        dma_busy;

  always #5 clk = ~clk;

  logic [7:0] ram [0:65535];
  assign mem_data_in = ram[mem_addr];

  oam_dma dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .dma_trigger(dma_trigger),
    .dma_page(dma_page), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data_in(mem_data_in), .ppu_reg_cs(ppu_reg_cs), .ppu_reg_addr(ppu_reg_addr),
    .ppu_WE(ppu_WE), .ppu_data_out(ppu_data_out), .cpu_halt(cpu_halt), .dma_busy(dma_busy)
  );

  int nchk = 0, npass = 0;
  int ce_div = 1, ce_cnt = 0;
  int wr_cnt = 0, halt_cnt = 0, exp_halt = 0;
  logic [15:0] addr_q[$];
  logic [7:0]  data_q[$];
  logic        tb_par;
  logic        last_pending = 1'b0;
  logic        prev_ce = 1'b1;
  logic [15:0] prev_addr = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // cpu_ce: high for one clk out of every ce_div clks
  initial forever begin
    @(posedge clk); #1;
    ce_cnt++;
    cpu_ce = (ce_cnt % ce_div == 0);
  end

  // reference CPU-cycle parity
  always @(posedge clk or negedge reset)
    if (!reset) tb_par <= 1'b0;
    else if (cpu_ce) tb_par <= ~tb_par;

  always @(negedge clk) begin
    if (cpu_halt && cpu_ce) halt_cnt++;
    if (mem_rd) begin
      chk("rd_strobe_ce", 32'(cpu_ce), 32'd1);
      if (addr_q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_read: addr %0h with empty queue", mem_addr);
      end else chk("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
    end
    if (ppu_WE || ppu_reg_cs) begin
      chk("wr_strobe_ce", 32'(cpu_ce), 32'd1);
      chk("wr_cs_we", 32'({ppu_reg_cs, ppu_WE}), 32'd3);
      chk("wr_reg_addr", 32'(ppu_reg_addr), 32'd4);
      chk("busy_in_write", 32'({dma_busy, cpu_halt}), 32'd3);
      if (data_q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_write: data %0h with empty queue", ppu_data_out);
      end else begin
        chk("wr_data", 32'(ppu_data_out), 32'(data_q.pop_front()));
        if (data_q.size() == 0) last_pending = 1'b1;
      end
      wr_cnt++;
    end else if (last_pending) begin
      chk("busy_fall", 32'({dma_busy, cpu_halt}), 32'd0);
      chk("halt_len", 32'(halt_cnt), 32'(exp_halt));
      last_pending = 1'b0;
    end
    if (ce_div > 1 && dma_busy && !prev_ce) chk("addr_gap_stable", 32'(mem_addr), 32'(prev_addr));
    prev_ce   = cpu_ce;
    prev_addr = mem_addr;
  end

  // want_par: 0/1 selects trigger-cycle parity, -1 any; push=0 for triggers the DUT must ignore
  task automatic trig(input logic [7:0] pg, input int want_par, input bit push);
    int n = 0;
    @(posedge clk); #2;
    while (!(cpu_ce && (want_par < 0 || tb_par == want_par[0])) && n < 100) begin
      @(posedge clk); #2; n++;
    end
    dma_trigger = 1'b1;
    dma_page    = pg;
    if (push) begin
      exp_halt = tb_par ? 514 : 513;
      halt_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        addr_q.push_back({pg, 8'(i)});
        data_q.push_back(ram[{pg, 8'(i)}]);
      end
    end
    @(posedge clk); #2;
    dma_trigger = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((data_q.size() != 0 || dma_busy) && n < budget) begin
      @(posedge clk); n++;
    end
    nchk++;
    if (n >= budget) $display("FAIL transfer_timeout: %0d writes pending after %0d clks", data_q.size(), n);
    else npass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_halt_busy"}, 32'({cpu_halt, dma_busy}), 32'd0);
    chk({tag, "_strobes"}, 32'({mem_rd, ppu_reg_cs, ppu_WE}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_reg_addr"}, 32'(ppu_reg_addr), 32'd0);
    chk({tag, "_data_out"}, 32'(ppu_data_out), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'((i * 13) + (i >> 8) * 7 + 1) ^ 8'hA5;

    repeat (3) @(posedge clk); #2;
    chk_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // even start: no ALIGN, 513 halted cycles
    wr_cnt = 0;
    trig(8'h02, 0, 1'b1);
    wait_done(2000);
    chk("even_write_count", 32'(wr_cnt), 32'd256);
    chk("idle_hold_addr", 32'(mem_addr), 32'h02FF);
    chk("idle_hold_data", 32'(ppu_data_out), 32'(ram[16'h02FF]));
    chk("idle_hold_reg", 32'(ppu_reg_addr), 32'd4);
    chk("idle_no_strobe", 32'({mem_rd, ppu_reg_cs, ppu_WE}), 32'd0);

    // odd start: one ALIGN cycle, 514 halted cycles
    wr_cnt = 0;
    trig(8'h02, 1, 1'b1);
    wait_done(2000);
    chk("odd_write_count", 32'(wr_cnt), 32'd256);

    // retrigger during transfer must be ignored
    wr_cnt = 0;
    trig(8'h02, -1, 1'b1);
    repeat (50) @(posedge clk);
    trig(8'h07, -1, 1'b0);
    repeat (200) @(posedge clk);
    trig(8'h07, -1, 1'b0);
    wait_done(2000);
    chk("retrig_write_count", 32'(wr_cnt), 32'd256);

    // gated enable: cpu_ce every 3rd clk
    ce_div = 3;
    wr_cnt = 0;
    trig(8'h02, -1, 1'b1);
    wait_done(4000);
    chk("gated_write_count", 32'(wr_cnt), 32'd256);

    // reset mid-transfer at write 100, then a fresh transfer from page 3
    ce_div = 1;
    repeat (4) @(posedge clk);
    wr_cnt = 0;
    trig(8'h03 - 8'h01, -1, 1'b1);
    begin
      int n = 0;
      while (wr_cnt < 100 && n < 2000) begin @(posedge clk); n++; end
      chk("reach_write_100", 32'(wr_cnt), 32'd100);
    end
    #3 reset = 1'b0;
    #1 chk_outputs_zero("midreset");
    addr_q.delete();
    data_q.delete();
    last_pending = 1'b0;
    repeat (3) @(posedge clk); #2;
    chk_outputs_zero("held_reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    wr_cnt = 0;
    trig(8'h03, -1, 1'b1);
    wait_done(2000);
    chk("after_reset_write_count", 32'(wr_cnt), 32'd256);
    chk("after_reset_last_addr", 32'(mem_addr), 32'h03FF);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
